adder4_2: RTL and testbench
===========================

# adder4_2

4-bit ripple-carry adder with carry-in and carry-out, plus a registered copy of the result and status flags. It is the datapath adder used by upstream arithmetic blocks. Consumers that can absorb combinational delay read `S`/`Cout` directly; consumers that need a clean register boundary read the `_q` outputs.

## Interface
Parameters:
- `WIDTH`, default 4: operand and sum width. The block is specified and verified at 4; other values must still elaborate and work.

Ports:
- `clk`  in  1: single clock, rising-edge active.
- `rst`  in  1: reset, asynchronous and active-high; clears all registered outputs.
- `A`  in  WIDTH: operand A, unsigned (also interpreted as two's-complement for `Ovf`).
- `B`  in  WIDTH: operand B, same encoding as `A`.
- `Cin`  in  1: carry-in.
- `S`  out  WIDTH: combinational sum, `(A + B + Cin) mod 2^WIDTH`.
- `Cout`  out  1: combinational carry-out, bit WIDTH of `A + B + Cin`.
- `S_q`  out  WIDTH: `S` registered on `clk`.
- `Cout_q`  out  1: `Cout` registered on `clk`.
- `Ovf_q`  out  1: registered signed overflow.
- `Zero_q`  out  1: registered flag, high when `S == 0`.

## Operation
- Full-width result is {Cout, S} = A + B + Cin, computed in WIDTH+1 bits. No saturation; the result wraps modulo 2^WIDTH.
- Structure: a ripple chain of WIDTH full-adder cells.
  - Bit 0 takes carry-in `Cin`.
  - Bit i takes carry-in c[i], which is the carry-out of bit i-1.
  - `Cout` is the carry-out of bit WIDTH-1.
- Full-adder cell equations:
  - s = a ^ b ^ ci
  - co = (a & b) | (ci & (a ^ b))
- Signed overflow: ovf = c[WIDTH] ^ c[WIDTH-1], where c[WIDTH-1] is the carry into the MSB.
- Zero flag: zero = ~|S. It is evaluated on S only; Cout is ignored.
- `S` and `Cout` are purely combinational. They ignore `clk` and `rst`, and are valid whenever the inputs are stable, including while `rst` is high.

## Timing
- Combinational path: `A`/`B`/`Cin` to `S`/`Cout`, zero cycles. Worst case is the full ripple (for example 1111 + 0000 + Cin=1).
- Registered path: `S_q`, `Cout_q`, `Ovf_q`, `Zero_q` update on every rising `clk` edge with the values at that edge. Latency is 1 cycle. There is no enable and no handshake.
- Reset: while `rst` is high, `S_q` = 0, `Cout_q` = 0, `Ovf_q` = 0, `Zero_q` = 0, asynchronously and immediately.
  - Reset is deliberately not consistent with the arithmetic: `Zero_q` is 0 during reset even though `S_q` is 0.
  - Reset asserted mid-stream clears the registers at once and discards the in-flight result.
  - The first capture after release occurs at the first rising edge with `rst` low.
- Input changes between edges affect only `S`/`Cout`. Registered outputs hold until the next edge.

## Structure
- Sub-module `full_adder`: 1-bit cell with ports a, b, ci, s, co. Instantiate it WIDTH times through a generate loop.
- Top `adder4_2`: carry vector c[WIDTH:0], flag logic, and one always_ff block with async reset.
- A shared package is optional. If the codebase arithmetic package exists, put the `WIDTH` default there as the constant `ADD_W = 4`. No typedefs are needed.

## Test plan
Each `_q` check is made one clock edge after the inputs are applied.
- All zeros: A=0000, B=0000, Cin=0 -> S=0000, Cout=0. One edge later `Zero_q`=1, `Ovf_q`=0.
- Carry chain: A=0011, B=0001, Cin=0 -> S=0100, Cout=0. Then A=0111, B=0011 -> S=1010, Cout=0, `Ovf_q`=1.
- Wrap-around: A=1111, B=1111, Cin=0 -> S=1110, Cout=1, `Ovf_q`=0. With Cin=1 -> S=1111, Cout=1.
- Carry-in only: A=0000, B=0000, Cin=1 -> S=0001, Cout=0, `Zero_q`=0. Also A=0111, B=0111, Cin=1 -> S=1111, Cout=0, `Ovf_q`=1.
- Full ripple / zero with carry: A=1111, B=0000, Cin=1 -> S=0000, Cout=1. One edge later `Zero_q`=1, `Cout_q`=1.
- Reset: assert `rst` asynchronously between edges while S=1110.
  - `_q` outputs go to 0 immediately; `S`/`Cout` stay 1110/1.
  - After release, the first edge loads 1110/1.
- Exhaustive sweep of all 512 A/B/Cin combinations against a reference model, for both the combinational and the registered outputs.

Source files
------------

// File: rtl/adder4_2_pkg.sv
// Shared arithmetic constants for the adder datapath.
package adder4_2_pkg;

  localparam int unsigned ADD_W = 4;

endpackage : adder4_2_pkg

// File: rtl/adder4_2_full_adder.sv
// One-bit full-adder cell, chained by adder4_2 into a ripple-carry adder.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  logic w_p;

  assign w_p = a ^ b;
  assign s   = w_p ^ ci;
  assign co  = (a & b) | (ci & w_p);

endmodule : full_adder

// File: rtl/adder4_2.sv
// Ripple-carry adder with combinational sum/carry and a registered copy
// of the result plus overflow and zero flags.
module adder4_2
  import adder4_2_pkg::*;
#(
  parameter int unsigned WIDTH = ADD_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic [WIDTH-1:0] S,
  output logic             Cout,
  output logic [WIDTH-1:0] S_q,
  output logic             Cout_q,
  output logic             Ovf_q,
  output logic             Zero_q
);

  logic [WIDTH:0]   w_c;
  logic [WIDTH-1:0] w_s;
  logic             w_ovf;
  logic             w_zero;

  logic [WIDTH-1:0] r_s;
  logic             r_cout;
  logic             r_ovf;
  logic             r_zero;

  assign w_c[0] = Cin;

  // Carry ripples LSB to MSB through one cell per bit.
  for (genvar i = 0; i < int'(WIDTH); i++) begin : g_fa
    full_adder u_fa (
      .a  (A[i]),
      .b  (B[i]),
      .ci (w_c[i]),
      .s  (w_s[i]),
      .co (w_c[i+1])
    );
  end

  assign w_ovf  = w_c[WIDTH] ^ w_c[WIDTH-1];
  assign w_zero = ~|w_s;

  assign S    = w_s;
  assign Cout = w_c[WIDTH];

  // Reset clears every flag, including Zero, regardless of the cleared sum.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s    <= '0;
      r_cout <= 1'b0;
      r_ovf  <= 1'b0;
      r_zero <= 1'b0;
    end else begin
      r_s    <= w_s;
      r_cout <= w_c[WIDTH];
      r_ovf  <= w_ovf;
      r_zero <= w_zero;
    end
  end

  assign S_q    = r_s;
  assign Cout_q = r_cout;
  assign Ovf_q  = r_ovf;
  assign Zero_q = r_zero;

endmodule : adder4_2

// File: tb/tb_adder4_2.sv
// Scoreboard bench for adder4_2: integer reference model, directed, exhaustive and random stimulus.
module tb_adder4_2;

  localparam int unsigned W = 4;

  typedef struct packed {
    logic [W-1:0] s;
    logic         c;
    logic         o;
    logic         z;
  } exp_t;

  logic         clk;
  logic         rst;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         Cin;
  logic [W-1:0] S;
  logic         Cout;
  logic [W-1:0] S_q;
  logic         Cout_q;
  logic         Ovf_q;
  logic         Zero_q;

  int checks = 0;
  int errors = 0;
  exp_t q[$];

  adder4_2 #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst    (rst),
    .A      (A),
    .B      (B),
    .Cin    (Cin),
    .S      (S),
    .Cout   (Cout),
    .S_q    (S_q),
    .Cout_q (Cout_q),
    .Ovf_q  (Ovf_q),
    .Zero_q (Zero_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: plain unsigned and signed integer arithmetic.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci);
    exp_t m;
    int   u;
    int   sa;
    int   sb;
    int   ss;
    u  = int'(a) + int'(b) + int'(ci);
    sa = (int'(a) >= 8) ? int'(a) - 16 : int'(a);
    sb = (int'(b) >= 8) ? int'(b) - 16 : int'(b);
    ss = sa + sb + int'(ci);
    m.s = W'(u % 16);
    m.c = (u >= 16);
    m.o = (ss > 7) || (ss < -8);
    m.z = ((u % 16) == 0);
    return m;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Apply operands between edges, check the combinational outputs, queue the registered expectation.
  task automatic apply(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci);
    exp_t m;
    @(negedge clk);
    A = a; B = b; Cin = ci;
    #1;
    m = model(a, b, ci);
    check("S", int'(S), int'(m.s));
    check("Cout", int'(Cout), int'(m.c));
    q.push_back(m);
  endtask

  // Monitor: every rising edge retires one expectation against the registered outputs.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        check("S_q", int'(S_q), int'(e.s));
        check("Cout_q", int'(Cout_q), int'(e.c));
        check("Ovf_q", int'(Ovf_q), int'(e.o));
        check("Zero_q", int'(Zero_q), int'(e.z));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; A = '0; B = '0; Cin = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_S_q", int'(S_q), 0);
    check("rst_Cout_q", int'(Cout_q), 0);
    check("rst_Ovf_q", int'(Ovf_q), 0);
    check("rst_Zero_q", int'(Zero_q), 0);
    @(negedge clk);
    rst = 1'b0;

    // Directed cases from the test plan.
    apply(4'b0000, 4'b0000, 1'b0);
    apply(4'b0011, 4'b0001, 1'b0);
    apply(4'b0111, 4'b0011, 1'b0);
    apply(4'b1111, 4'b1111, 1'b0);
    apply(4'b1111, 4'b1111, 1'b1);
    apply(4'b0000, 4'b0000, 1'b1);
    apply(4'b0111, 4'b0111, 1'b1);
    apply(4'b1111, 4'b0000, 1'b1);
    apply(4'b1000, 4'b1000, 1'b0);

    // Mid-stream asynchronous reset while S = 1110.
    apply(4'b1111, 4'b1111, 1'b0);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("async_S_q", int'(S_q), 0);
    check("async_Cout_q", int'(Cout_q), 0);
    check("async_Ovf_q", int'(Ovf_q), 0);
    check("async_Zero_q", int'(Zero_q), 0);
    check("rst_comb_S", int'(S), 'he);
    check("rst_comb_Cout", int'(Cout), 1);
    q.push_back('0);
    @(negedge clk);
    rst = 1'b0;
    q.push_back(model(4'b1111, 4'b1111, 1'b0));

    // Exhaustive sweep.
    for (int i = 0; i < 512; i++) begin
      apply(W'(i & 15), W'((i >> 4) & 15), 1'(i >> 8));
    end

    // Random tail.
    for (int i = 0; i < 100; i++) begin
      apply(W'($urandom_range(15, 0)), W'($urandom_range(15, 0)), 1'($urandom_range(1, 0)));
    end

    repeat (3) @(posedge clk);
    #2;
    check("queue_drained", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_adder4_2
